// File: rtl/apb_slave_regbank_pkg.sv
// Shared types and helpers for the APB register bank: FSM encoding, word size and
// the address decode error rule.
package apb_slave_regbank_pkg;

  typedef enum logic {APB_IDLE, APB_ACCESS} apb_state_e;

  localparam int APB_WORD_BYTES = 4;

  typedef logic [31:0] apb_data_t;

  // Addresses are widened to 64 bits so the rule holds for any ADDR_W up to 64.
  function automatic logic apb_addr_err(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input logic [63:0] num_regs);
    logic [63:0] idx;
    idx = (addr - base) / 64'(APB_WORD_BYTES);
    return (addr[1:0] != 2'b00) || (addr < base) || (idx >= num_regs);
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB3 bus bundle between a requester (master) and the register bank (slave).
interface apb_slave_regbank_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: a transfer starts with a setup cycle (psel=1, penable=0), then holds
  // psel=1, penable=1 and all request fields stable until the slave answers with
  // pready=1; that cycle completes it. pslverr and prdata are meaningful only there.
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_slave_regbank_regbank.sv
// Word register storage for the APB bank: one write port, one combinational read
// port, cleared by the asynchronous reset.
module apb_slave_regbank_regbank
  import apb_slave_regbank_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  apb_data_t        wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output apb_data_t        rd_data
);

  apb_data_t mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we && (int'(wr_idx) < NUM_REGS)) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Indices past NUM_REGS only occur for non-power-of-two sizes on errored decodes.
  assign rd_data = (int'(rd_idx) < NUM_REGS) ? mem[rd_idx] : '0;

endmodule

// File: rtl/apb_slave_regbank.sv
// APB3 completer serving NUM_REGS word registers with a fixed number of wait states
// per transfer and pslverr for misaligned or out-of-range addresses.
module apb_slave_regbank
  import apb_slave_regbank_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_REGS    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                rst_n,
  apb_slave_regbank_if.slave  apb,
  output apb_state_e          dbg_state
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_state_e        state, state_d;
  logic [3:0]        cnt, cnt_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_err;
  logic              we;
  logic [IDX_W-1:0]  rd_idx;
  apb_data_t         rd_data;

  assign off     = apb.paddr - BASE_ADDR;
  assign dec_idx = IDX_W'(off >> 2);
  assign dec_err = apb_addr_err(64'(apb.paddr), 64'(BASE_ADDR), 64'(NUM_REGS));

  apb_slave_regbank_regbank #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regbank (
    .clk     (pclk),
    .rst_n   (rst_n),
    .we      (we),
    .wr_idx  (idx_q),
    .wr_data (apb.pwdata),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= APB_IDLE;
      cnt       <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    wr_d      = wr_q;
    err_d     = err_q;
    idx_d     = idx_q;
    we        = 1'b0;
    rd_idx    = idx_q;
    unique case (state)
      APB_IDLE: begin
        rd_idx = dec_idx;
        if (apb.psel && !apb.penable) begin
          state_d = APB_ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
          wr_d    = apb.pwrite;
          err_d   = dec_err;
          idx_d   = dec_idx;
          if (WAIT_CYCLES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = dec_err;
            prdata_d  = (apb.pwrite || dec_err) ? '0 : rd_data;
          end
        end
      end
      APB_ACCESS: begin
        if (!apb.psel) begin
          // Requester walked away mid-transfer: drop it without touching storage.
          state_d   = APB_IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (pready_q) begin
          if (apb.penable) begin
            we        = wr_q && !err_q;
            state_d   = APB_IDLE;
            pready_d  = 1'b0;
            pslverr_d = 1'b0;
            prdata_d  = '0;
          end
        end else begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (wr_q || err_q) ? '0 : rd_data;
          end
        end
      end
      default: state_d = APB_IDLE;
    endcase
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: three instances (0, 2 and 3 wait states) share one
// driver; a monitor checks every completion against a reference register model.
module tb_apb_slave_regbank;
  import apb_slave_regbank_pkg::*;

  localparam int NREG = 16;

  // ---------------- clock / reset ----------------
  logic pclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 pclk = ~pclk;

  // ---------------- shared requester signals ----------------
  logic        m_psel    = 1'b0;
  logic        m_penable = 1'b0;
  logic        m_pwrite  = 1'b0;
  logic [31:0] m_paddr   = '0;
  logic [31:0] m_pwdata  = '0;
  logic [1:0]  sel       = 2'd0;

  logic [2:0]  v_pready;
  logic [2:0]  v_pslverr;
  logic [31:0] v_prdata [3];
  apb_state_e  v_state  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
    apb_slave_regbank_if bus ();
    assign bus.psel    = m_psel && (sel == 2'(g));
    assign bus.penable = m_penable;
    assign bus.pwrite  = m_pwrite;
    assign bus.paddr   = m_paddr;
    assign bus.pwdata  = m_pwdata;
    apb_slave_regbank #(
      .NUM_REGS    (NREG),
      .WAIT_CYCLES (W)
    ) u_dut (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .apb       (bus),
      .dbg_state (v_state[g])
    );
    assign v_pready[g]  = bus.pready;
    assign v_pslverr[g] = bus.pslverr;
    assign v_prdata[g]  = bus.prdata;
  end

  logic        cur_pready, cur_pslverr;
  logic [31:0] cur_prdata;
  always_comb begin
    cur_pready  = v_pready[sel];
    cur_pslverr = v_pslverr[sel];
    cur_prdata  = v_prdata[sel];
  end

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] model [3][NREG];
  // entry = {is_read, err, waits[3:0], rdata[31:0]}
  logic [37:0] exp_q [$];
  int n_total = 0;
  int n_bad   = 0;

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < NREG; i++) model[d][i] = '0;
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; returns just after the completion edge.
  task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata);
    logic        err;
    logic [31:0] exp_rd;
    int          guard;
    err    = (addr % 4 != 0) || (addr / 4 >= NREG);
    exp_rd = (wr || err) ? 32'h0 : model[d][addr / 4];
    exp_q.push_back({!wr, err, 4'(wait_of(d)), exp_rd});
    if (wr && !err) model[d][addr / 4] = wdata;
    sel = 2'(d); m_psel = 1'b1; m_penable = 1'b0;
    m_pwrite = wr; m_paddr = addr; m_pwdata = wdata;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    guard = 0;
    forever begin
      @(negedge pclk);
      if (cur_pready) break;
      guard++;
      if (guard > 40) begin
        n_total++; n_bad++;
        $display("FAIL timeout: no pready on dut %0d addr 0x%08h", d, addr);
        break;
      end
    end
    @(posedge pclk); #1;
    m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  // ---------------- monitor ----------------
  int          lat = 0;
  logic [37:0] e;
  always @(negedge pclk) begin
    if (rst_n) begin
      if (!cur_pready) begin
        chk("pslverr_without_pready", {31'b0, cur_pslverr}, 32'h0);
        chk("prdata_without_pready", cur_prdata, 32'h0);
      end
      if (m_psel && !m_penable) lat = 0;
      else if (m_psel && m_penable && !cur_pready) lat++;
      else if (m_psel && m_penable && cur_pready) begin
        if (exp_q.size() == 0) begin
          n_total++; n_bad++;
          $display("FAIL unexpected_completion: pready=1 with empty queue at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("wait_states", 32'(lat), 32'(e[35:32]));
          chk("pslverr", {31'b0, cur_pslverr}, {31'b0, e[36]});
          if (e[37]) chk("prdata", cur_prdata, e[31:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] a;
  initial begin
    clear_model();
    repeat (3) @(posedge pclk);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk("rst_pready",  {31'b0, v_pready[g]},  32'h0);
      chk("rst_pslverr", {31'b0, v_pslverr[g]}, 32'h0);
      chk("rst_prdata",  v_prdata[g], 32'h0);
      chk("rst_state",   32'(v_state[g]), 32'(APB_IDLE));
    end
    @(negedge pclk) rst_n = 1'b1;
    @(posedge pclk); #1;

    // Reset in the middle of a 3-wait write aborts it.
    sel = 2'd2; m_psel = 1'b1; m_penable = 1'b0;
    m_pwrite = 1'b1; m_paddr = 32'h4; m_pwdata = 32'hDEADBEEF;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    @(posedge pclk); #2;
    chk("mid_access_state", 32'(v_state[2]), 32'(APB_ACCESS));
    rst_n = 1'b0; #1;
    chk("async_rst_pready",  {31'b0, v_pready[2]},  32'h0);
    chk("async_rst_pslverr", {31'b0, v_pslverr[2]}, 32'h0);
    chk("async_rst_prdata",  v_prdata[2], 32'h0);
    chk("async_rst_state",   32'(v_state[2]), 32'(APB_IDLE));
    m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
    clear_model();
    @(negedge pclk) rst_n = 1'b1;
    @(posedge pclk); #1;
    apb_xfer(2, 1'b0, 32'h4, 32'h0);

    // Zero-wait write then read.
    apb_xfer(0, 1'b1, 32'h8, 32'h12345678);
    apb_xfer(0, 1'b0, 32'h8, 32'h0);

    // Two-wait write/read.
    apb_xfer(1, 1'b1, 32'h0, 32'hCAFE0001);
    apb_xfer(1, 1'b0, 32'h0, 32'h0);

    // Error responses; errored write must not land anywhere.
    apb_xfer(0, 1'b0, 32'h3,  32'h0);
    apb_xfer(0, 1'b0, 32'h40, 32'h0);
    apb_xfer(0, 1'b1, 32'h40, 32'hFFFFFFFF);
    apb_xfer(0, 1'b1, 32'h6,  32'hFFFFFFFF);
    for (int i = 0; i < NREG; i++) apb_xfer(0, 1'b0, 32'(i * 4), 32'h0);

    // Back-to-back write then read, no idle gap.
    apb_xfer(0, 1'b1, 32'hC, 32'hA);
    apb_xfer(0, 1'b0, 32'hC, 32'h0);
    apb_xfer(1, 1'b1, 32'hC, 32'hB);
    apb_xfer(1, 1'b0, 32'hC, 32'h0);

    // Abort by dropping psel during a wait state.
    apb_xfer(1, 1'b1, 32'h10, 32'h55);
    sel = 2'd1; m_psel = 1'b1; m_penable = 1'b0;
    m_pwrite = 1'b1; m_paddr = 32'h10; m_pwdata = 32'h99;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    @(posedge pclk); #1;
    m_psel = 1'b0; m_penable = 1'b0;
    @(posedge pclk); #1;
    chk("abort_state", 32'(v_state[1]), 32'(APB_IDLE));
    chk("abort_pready", {31'b0, v_pready[1]}, 32'h0);
    apb_xfer(1, 1'b0, 32'h10, 32'h0);

    // penable without a setup cycle is ignored.
    sel = 2'd0; m_psel = 1'b1; m_penable = 1'b1; m_pwrite = 1'b1;
    m_paddr = 32'h14; m_pwdata = 32'h77;
    repeat (3) begin
      @(posedge pclk); #1;
      chk("no_setup_state", 32'(v_state[0]), 32'(APB_IDLE));
    end
    m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0;
    idle(1);
    apb_xfer(0, 1'b0, 32'h14, 32'h0);

    // Randomized traffic across all three instances.
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 25; k++) begin
        a = 32'($urandom_range(0, 18)) * 32'd4;
        if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
        apb_xfer(d, 1'($urandom_range(0, 1)), a, $urandom);
        if ($urandom_range(0, 1) == 1) idle(1);
      end
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge pclk);
    chk("leftover_expectations", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
